// File: rtl/slurm_regfile_pkg.sv
// rtl/slurm_regfile_pkg.sv - shared types and helpers for the banked register file
package slurm_regfile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CLEAR   = 2'd1,
        ST_COPY_RD = 2'd2,
        ST_COPY_WR = 2'd3
    } seq_state_t;

    function automatic int depth(input int reg_bits, input int bank_bits);
        return 2 ** (reg_bits + bank_bits);
    endfunction

    // Packed multi-port buses place port p at [p*width +: width].
    function automatic int slice_lo(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_ram_1r1w.sv
// rtl/regfile_ram_1r1w.sv - 1R1W block RAM with registered, write-first read port
module regfile_ram_1r1w #(
    parameter int AW = 6,
    parameter int DW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [2**AW];
    logic [DW-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/banked_register_file.sv
// rtl/banked_register_file.sv - multi-read banked register file with clear/copy sequencer
module banked_register_file
    import slurm_regfile_pkg::*;
#(
    parameter int REG_BITS  = 5,
    parameter int BITS      = 16,
    parameter int BANK_BITS = 1,
    parameter int NUM_READ  = 2
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [BANK_BITS-1:0]         bank_sel,
    input  logic                         wr_en,
    input  logic [REG_BITS-1:0]          wr_reg,
    input  logic [BITS-1:0]              wr_data,
    input  logic [NUM_READ*REG_BITS-1:0] rd_reg,
    output logic [NUM_READ*BITS-1:0]     rd_data,
    input  logic                         copy_start,
    input  logic [BANK_BITS-1:0]         copy_src,
    input  logic [BANK_BITS-1:0]         copy_dst,
    output logic                         busy,
    output logic                         copy_done
);

    localparam int AW    = REG_BITS + BANK_BITS;
    localparam int DEPTH = depth(REG_BITS, BANK_BITS);

    seq_state_t           r_state;
    logic [AW-1:0]        r_addr;
    logic [REG_BITS-1:0]  r_idx;
    logic [REG_BITS-1:0]  r_wr_idx;
    logic [BANK_BITS-1:0] r_src;
    logic [BANK_BITS-1:0] r_dst;
    logic                 r_copy_done;
    logic                 r_rd0_seq;
    logic [BITS-1:0]      r_rd0_hold;

    logic                 w_we;
    logic [AW-1:0]        w_waddr;
    logic [BITS-1:0]      w_wdata;
    logic                 w_user_re;
    logic                 w_seq_re;
    logic [AW-1:0]        w_seq_raddr;
    logic [BITS-1:0]      w_rdata [NUM_READ];

    always_comb begin
        w_we        = 1'b0;
        w_waddr     = '0;
        w_wdata     = '0;
        w_user_re   = 1'b0;
        w_seq_re    = 1'b0;
        w_seq_raddr = {r_src, r_idx};
        case (r_state)
            ST_IDLE: begin
                w_we      = wr_en;
                w_waddr   = {bank_sel, wr_reg};
                w_wdata   = wr_data;
                w_user_re = 1'b1;
            end
            ST_CLEAR: begin
                w_we    = 1'b1;
                w_waddr = r_addr;
            end
            ST_COPY_RD: begin
                w_seq_re = 1'b1;
            end
            ST_COPY_WR: begin
                w_we     = 1'b1;
                w_waddr  = {r_dst, r_wr_idx};
                w_wdata  = w_rdata[0];
                w_seq_re = ~&r_wr_idx;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_CLEAR;
            r_addr      <= '0;
            r_idx       <= '0;
            r_wr_idx    <= '0;
            r_src       <= '0;
            r_dst       <= '0;
            r_copy_done <= 1'b0;
            r_rd0_seq   <= 1'b0;
            r_rd0_hold  <= '0;
        end else begin
            r_copy_done <= 1'b0;
            // Port 0 shares its RAM with the copy engine; keep its last user value visible.
            if (!r_rd0_seq) begin
                r_rd0_hold <= w_rdata[0];
            end
            if (w_seq_re) begin
                r_rd0_seq <= 1'b1;
            end else if (w_user_re) begin
                r_rd0_seq <= 1'b0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (copy_start) begin
                        if (copy_src == copy_dst) begin
                            r_copy_done <= 1'b1;
                        end else begin
                            r_src   <= copy_src;
                            r_dst   <= copy_dst;
                            r_idx   <= '0;
                            r_state <= ST_COPY_RD;
                        end
                    end
                end
                ST_CLEAR: begin
                    r_addr <= r_addr + 1'b1;
                    if (r_addr == AW'(DEPTH - 1)) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COPY_RD: begin
                    r_wr_idx <= r_idx;
                    r_idx    <= r_idx + 1'b1;
                    r_state  <= ST_COPY_WR;
                end
                ST_COPY_WR: begin
                    if (&r_wr_idx) begin
                        r_state     <= ST_IDLE;
                        r_copy_done <= 1'b1;
                    end else begin
                        r_wr_idx <= r_idx;
                        r_idx    <= r_idx + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    for (genvar p = 0; p < NUM_READ; p++) begin : g_copy
        logic [AW-1:0] w_raddr;
        logic          w_re;

        if (p == 0) begin : g_seq_port
            assign w_raddr = w_seq_re ? w_seq_raddr
                                      : {bank_sel, rd_reg[slice_lo(p, REG_BITS) +: REG_BITS]};
            assign w_re    = w_user_re | w_seq_re;
            assign rd_data[slice_lo(p, BITS) +: BITS] = r_rd0_seq ? r_rd0_hold : w_rdata[p];
        end else begin : g_user_port
            assign w_raddr = {bank_sel, rd_reg[slice_lo(p, REG_BITS) +: REG_BITS]};
            assign w_re    = w_user_re;
            assign rd_data[slice_lo(p, BITS) +: BITS] = w_rdata[p];
        end

        regfile_ram_1r1w #(
            .AW (AW),
            .DW (BITS)
        ) u_ram (
            .i_clk   (CLK),
            .i_rst   (RST),
            .i_we    (w_we),
            .i_waddr (w_waddr),
            .i_wdata (w_wdata),
            .i_re    (w_re),
            .i_raddr (w_raddr),
            .o_rdata (w_rdata[p])
        );
    end

    assign busy      = (r_state != ST_IDLE);
    assign copy_done = r_copy_done;

endmodule

// File: tb/tb_banked_register_file.sv
// tb/tb_banked_register_file.sv - directed self-checking bench for banked_register_file
module tb_banked_register_file;

    logic        CLK;
    logic        RST;
    logic [0:0]  bank_sel;
    logic        wr_en;
    logic [4:0]  wr_reg;
    logic [15:0] wr_data;
    logic [9:0]  rd_reg;
    logic [31:0] rd_data;
    logic        copy_start;
    logic [0:0]  copy_src;
    logic [0:0]  copy_dst;
    logic        busy;
    logic        copy_done;

    int errors = 0;
    int checks = 0;

    banked_register_file #(
        .REG_BITS  (5),
        .BITS      (16),
        .BANK_BITS (1),
        .NUM_READ  (2)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .bank_sel   (bank_sel),
        .wr_en      (wr_en),
        .wr_reg     (wr_reg),
        .wr_data    (wr_data),
        .rd_reg     (rd_reg),
        .rd_data    (rd_data),
        .copy_start (copy_start),
        .copy_src   (copy_src),
        .copy_dst   (copy_dst),
        .busy       (busy),
        .copy_done  (copy_done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic b, input logic [4:0] r0, input logic [4:0] r1,
                      output logic [15:0] d0, output logic [15:0] d1);
        bank_sel = b;
        rd_reg   = {r1, r0};
        tick();
        d0 = rd_data[15:0];
        d1 = rd_data[31:16];
    endtask

    task automatic wr(input logic b, input logic [4:0] r, input logic [15:0] d);
        bank_sel = b;
        wr_reg   = r;
        wr_data  = d;
        wr_en    = 1'b1;
        tick();
        wr_en    = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        logic [15:0] d0, d1;
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (rd_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h expected %h", rd_data, 32'h0);
        end
        checks++;
        if (busy !== 1'b1 || copy_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: busy=%b copy_done=%b expected busy=1 copy_done=0", busy, copy_done);
        end
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        checks++;
        if (n != 64) begin
            errors++;
            $display("FAIL reset_clear_cycles: got %0d expected 64", n);
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 32; i += 2) begin
                rd(b[0], 5'(i), 5'(i + 1), d0, d1);
                checks++;
                if (d0 !== 16'h0 || d1 !== 16'h0) begin
                    errors++;
                    $display("FAIL reset_zero b%0d r%0d: got %h/%h expected 0000/0000", b, i, d0, d1);
                end
            end
        end
    endtask

    task automatic test_bypass();
        logic [15:0] d0, d1;
        bank_sel = 1'b0;
        wr_reg   = 5'd3;
        wr_data  = 16'hBEEF;
        wr_en    = 1'b1;
        rd_reg   = {5'd3, 5'd3};
        tick();
        wr_en    = 1'b0;
        checks++;
        if (rd_data !== {16'hBEEF, 16'hBEEF}) begin
            errors++;
            $display("FAIL bypass_same_cycle: got %h expected %h", rd_data, {16'hBEEF, 16'hBEEF});
        end
        rd(1'b1, 5'd3, 5'd3, d0, d1);
        checks++;
        if (d0 !== 16'h0 || d1 !== 16'h0) begin
            errors++;
            $display("FAIL bypass_other_bank: got %h/%h expected 0000/0000", d0, d1);
        end
        rd(1'b0, 5'd3, 5'd4, d0, d1);
        checks++;
        if (d0 !== 16'hBEEF || d1 !== 16'h0) begin
            errors++;
            $display("FAIL bypass_stored: got %h/%h expected beef/0000", d0, d1);
        end
    endtask

    task automatic test_copy();
        logic [15:0] d0, d1;
        int busy_cnt, done_cnt, first_done, hold_err;
        for (int i = 0; i < 32; i++) begin
            wr(1'b0, 5'(i), 16'h1000 + 16'(i));
        end
        rd(1'b0, 5'd2, 5'd4, d0, d1);
        copy_src   = 1'b0;
        copy_dst   = 1'b1;
        copy_start = 1'b1;
        tick();
        copy_start = 1'b0;
        rd_reg     = {5'd8, 5'd7};
        busy_cnt = 0; done_cnt = 0; first_done = -1; hold_err = 0;
        for (int k = 0; k < 40; k++) begin
            if (busy === 1'b1) begin
                busy_cnt++;
                if (rd_data !== {16'h1004, 16'h1002}) hold_err++;
            end
            if (copy_done === 1'b1) begin
                done_cnt++;
                if (first_done < 0) first_done = k;
            end
            tick();
        end
        checks++;
        if (busy_cnt != 33) begin
            errors++;
            $display("FAIL copy_busy_cycles: got %0d expected 33", busy_cnt);
        end
        checks++;
        if (done_cnt != 1 || first_done != 33) begin
            errors++;
            $display("FAIL copy_done_pulse: got count %0d at %0d expected count 1 at 33", done_cnt, first_done);
        end
        checks++;
        if (hold_err != 0) begin
            errors++;
            $display("FAIL copy_rd_hold: got %0d changed samples expected 0", hold_err);
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 32; i += 2) begin
                rd(b[0], 5'(i), 5'(i + 1), d0, d1);
                checks++;
                if (d0 !== 16'h1000 + 16'(i) || d1 !== 16'h1001 + 16'(i)) begin
                    errors++;
                    $display("FAIL copy_data b%0d r%0d: got %h/%h expected %h/%h",
                             b, i, d0, d1, 16'h1000 + 16'(i), 16'h1001 + 16'(i));
                end
            end
        end
    endtask

    task automatic test_busy_write();
        logic [15:0] d0, d1;
        int busy_cnt, done_cnt;
        wr(1'b1, 5'd7, 16'h7777);
        copy_src   = 1'b0;
        copy_dst   = 1'b1;
        copy_start = 1'b1;
        tick();
        copy_start = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        for (int k = 0; k < 100; k++) begin
            if (busy === 1'b1) busy_cnt++;
            if (copy_done === 1'b1) done_cnt++;
            if (k == 5) begin
                bank_sel = 1'b0; wr_reg = 5'd5; wr_data = 16'h5555; wr_en = 1'b1;
                copy_src = 1'b1; copy_dst = 1'b0; copy_start = 1'b1;
            end else begin
                wr_en = 1'b0;
                copy_start = 1'b0;
            end
            tick();
        end
        checks++;
        if (busy_cnt != 33 || done_cnt != 1) begin
            errors++;
            $display("FAIL busy_second_copy: got busy %0d done %0d expected busy 33 done 1", busy_cnt, done_cnt);
        end
        rd(1'b0, 5'd5, 5'd7, d0, d1);
        checks++;
        if (d0 !== 16'h1005) begin
            errors++;
            $display("FAIL busy_write_dropped: got %h expected 1005", d0);
        end
        rd(1'b1, 5'd5, 5'd7, d0, d1);
        checks++;
        if (d0 !== 16'h1005 || d1 !== 16'h1007) begin
            errors++;
            $display("FAIL busy_copy_dst: got %h/%h expected 1005/1007", d0, d1);
        end
    endtask

    task automatic test_same_bank();
        logic [15:0] d0, d1;
        copy_src   = 1'b1;
        copy_dst   = 1'b1;
        copy_start = 1'b1;
        tick();
        copy_start = 1'b0;
        checks++;
        if (copy_done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL same_bank_pulse: copy_done=%b busy=%b expected 1/0", copy_done, busy);
        end
        tick();
        checks++;
        if (copy_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL same_bank_after: copy_done=%b busy=%b expected 0/0", copy_done, busy);
        end
        rd(1'b1, 5'd0, 5'd31, d0, d1);
        checks++;
        if (d0 !== 16'h1000 || d1 !== 16'h101F) begin
            errors++;
            $display("FAIL same_bank_data: got %h/%h expected 1000/101f", d0, d1);
        end
    endtask

    task automatic test_write_with_start();
        logic [15:0] d0, d1;
        int n;
        bank_sel   = 1'b0;
        wr_reg     = 5'd9;
        wr_data    = 16'h9999;
        wr_en      = 1'b1;
        copy_src   = 1'b0;
        copy_dst   = 1'b1;
        copy_start = 1'b1;
        tick();
        wr_en      = 1'b0;
        copy_start = 1'b0;
        n = 0;
        while (copy_done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        checks++;
        if (n != 33) begin
            errors++;
            $display("FAIL start_write_done_latency: got %0d expected 33", n);
        end
        tick();
        rd(1'b1, 5'd9, 5'd10, d0, d1);
        checks++;
        if (d0 !== 16'h9999 || d1 !== 16'h100A) begin
            errors++;
            $display("FAIL start_write_seen: got %h/%h expected 9999/100a", d0, d1);
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] d0, d1;
        int n, done_cnt;
        copy_src   = 1'b1;
        copy_dst   = 1'b0;
        copy_start = 1'b1;
        tick();
        copy_start = 1'b0;
        repeat (10) tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        checks++;
        if (busy !== 1'b1 || copy_done !== 1'b0 || rd_data !== 32'h0) begin
            errors++;
            $display("FAIL abort_reset_state: busy=%b copy_done=%b rd=%h expected 1/0/00000000", busy, copy_done, rd_data);
        end
        n = 0; done_cnt = 0;
        while (busy === 1'b1 && n < 200) begin
            if (copy_done === 1'b1) done_cnt++;
            tick();
            n++;
        end
        repeat (5) begin
            if (copy_done === 1'b1) done_cnt++;
            tick();
        end
        checks++;
        if (n != 64 || done_cnt != 0) begin
            errors++;
            $display("FAIL abort_clear: got busy %0d done %0d expected busy 64 done 0", n, done_cnt);
        end
        for (int b = 0; b < 2; b++) begin
            for (int i = 0; i < 32; i += 2) begin
                rd(b[0], 5'(i), 5'(i + 1), d0, d1);
                checks++;
                if (d0 !== 16'h0 || d1 !== 16'h0) begin
                    errors++;
                    $display("FAIL abort_zero b%0d r%0d: got %h/%h expected 0000/0000", b, i, d0, d1);
                end
            end
        end
    endtask

    initial begin
        RST        = 1'b1;
        bank_sel   = 1'b0;
        wr_en      = 1'b0;
        wr_reg     = '0;
        wr_data    = '0;
        rd_reg     = '0;
        copy_start = 1'b0;
        copy_src   = 1'b0;
        copy_dst   = 1'b0;
        test_reset();
        test_bypass();
        test_copy();
        test_busy_write();
        test_same_bank();
        test_write_with_start();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
